// File: rtl/alu_mdu_if.sv
// Request/response bus of the EX-stage execution unit.
// The core drives the master side; alu_mdu sits on the slave side.
interface alu_mdu_if #(
    parameter int LEN = 32
);
    logic           flush;
    logic           in_valid;
    logic           in_ready;
    logic [LEN-1:0] aluop1;
    logic [LEN-1:0] aluop2;
    logic [4:0]     alu_ctrl;
    logic           out_valid;
    logic           out_ready;
    logic [LEN-1:0] aluout;
    logic           zero;
    logic           busy;

    modport master (
        output flush, in_valid, aluop1, aluop2, alu_ctrl, out_ready,
        input  in_ready, out_valid, aluout, zero, busy
    );

    modport slave (
        input  flush, in_valid, aluop1, aluop2, alu_ctrl, out_ready,
        output in_ready, out_valid, aluout, zero, busy
    );
endinterface

// File: rtl/alu_mdu.sv
// Multi-cycle execution unit: single-cycle base ALU ops plus an iterative
// radix-2 multiply (shift-add) and restoring divide on operand magnitudes,
// with the signs applied in a final fix-up cycle.
module alu_mdu #(
    parameter  int LEN = 32,
    localparam int SHW = $clog2(LEN)
) (
    input logic      clk,
    input logic      rst_n,
    alu_mdu_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [4:0] OP_ADD    = 5'h00;
    localparam logic [4:0] OP_SUB    = 5'h01;
    localparam logic [4:0] OP_AND    = 5'h02;
    localparam logic [4:0] OP_OR     = 5'h03;
    localparam logic [4:0] OP_XOR    = 5'h04;
    localparam logic [4:0] OP_SLT    = 5'h05;
    localparam logic [4:0] OP_SLTU   = 5'h06;
    localparam logic [4:0] OP_SLL    = 5'h07;
    localparam logic [4:0] OP_SRL    = 5'h08;
    localparam logic [4:0] OP_SRA    = 5'h09;
    localparam logic [4:0] OP_MUL    = 5'h0A;
    localparam logic [4:0] OP_MULH   = 5'h0B;
    localparam logic [4:0] OP_MULHSU = 5'h0C;
    localparam logic [4:0] OP_MULHU  = 5'h0D;
    localparam logic [4:0] OP_DIV    = 5'h0E;
    localparam logic [4:0] OP_DIVU   = 5'h0F;
    localparam logic [4:0] OP_REM    = 5'h10;
    localparam logic [4:0] OP_REMU   = 5'h11;

    localparam logic [LEN-1:0] MIN_NEG = {1'b1, {(LEN-1){1'b0}}};
    localparam logic [SHW:0]   ITERS   = (SHW+1)'(LEN);

    logic [1:0]       state;
    logic [SHW:0]     cnt;
    logic [2*LEN-1:0] acc;      // MUL: {partial product, multiplier}; DIV: {remainder, quotient}
    logic [LEN-1:0]   opb;      // multiplicand or divisor magnitude
    logic [4:0]       op_q;
    logic             neg_q;    // negate the selected result in the fix-up cycle
    logic             out_valid_q;
    logic [LEN-1:0]   aluout_q;
    logic             zero_q;

    logic [LEN-1:0]   a, b, a_mag, b_mag, quick_res, fin_res, div_pick;
    logic [SHW-1:0]   shamt;
    logic             accept, is_mul, is_div, div_zero, div_ovf, go_div;
    logic             a_sgn, b_sgn, start_neg;
    logic [LEN:0]     mul_sum, div_shift, div_diff;
    logic [2*LEN-1:0] mul_next, div_next, prod_fix;

    assign a     = bus.aluop1;
    assign b     = bus.aluop2;
    assign shamt = b[SHW-1:0];

    assign bus.in_ready  = (state == S_IDLE) || (state == S_DONE && bus.out_ready);
    assign bus.busy      = (state == S_MUL) || (state == S_DIV);
    assign bus.out_valid = out_valid_q;
    assign bus.aluout    = aluout_q;
    assign bus.zero      = zero_q;

    // A request issued together with flush is dropped.
    assign accept = bus.in_valid && bus.in_ready && !bus.flush;

    // Decode the incoming request: operation class, divide special cases, operand magnitudes.
    always_comb begin
        is_mul   = bus.alu_ctrl inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
        is_div   = bus.alu_ctrl inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
        div_zero = (b == '0);
        div_ovf  = (bus.alu_ctrl inside {OP_DIV, OP_REM}) && (a == MIN_NEG) && (b == '1);
        go_div   = is_div && !div_zero && !div_ovf;
        a_sgn    = a[LEN-1] && (bus.alu_ctrl inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
        b_sgn    = b[LEN-1] && (bus.alu_ctrl inside {OP_MULH, OP_DIV, OP_REM});
        a_mag    = a_sgn ? -a : a;
        b_mag    = b_sgn ? -b : b;
        // Remainder takes the dividend's sign; products and quotients the XOR of both.
        start_neg = (bus.alu_ctrl == OP_REM) ? a_sgn : (a_sgn ^ b_sgn);
    end

    // Single-cycle results: base ops, unknown codes and divide special cases.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        quick_res = '0;
        case (bus.alu_ctrl)
            OP_ADD:           quick_res = a + b;
            OP_SUB:           quick_res = a - b;
            OP_AND:           quick_res = a & b;
            OP_OR:            quick_res = a | b;
            OP_XOR:           quick_res = a ^ b;
            OP_SLT:           quick_res = LEN'($signed(a) < $signed(b));
            OP_SLTU:          quick_res = LEN'(a < b);
            OP_SLL:           quick_res = a << shamt;
            OP_SRL:           quick_res = a >> shamt;
            OP_SRA:           quick_res = $signed(a) >>> shamt;
            OP_DIV, OP_DIVU:  quick_res = div_ovf ? a : '1;
            OP_REM, OP_REMU:  quick_res = div_ovf ? '0 : a;
            default:          quick_res = '0;
        endcase
    end

    // One iteration step of each datapath and the final sign fix-up.
    always_comb begin
        mul_sum   = {1'b0, acc[2*LEN-1:LEN]} + {1'b0, (acc[0] ? opb : '0)};
        mul_next  = {mul_sum, acc[LEN-1:1]};
        div_shift = {acc[2*LEN-1:LEN], acc[LEN-1]};
        div_diff  = div_shift - {1'b0, opb};
        div_next  = div_diff[LEN] ? {div_shift[LEN-1:0], acc[LEN-2:0], 1'b0}
                                  : {div_diff[LEN-1:0], acc[LEN-2:0], 1'b1};
        prod_fix  = neg_q ? -acc : acc;
        div_pick  = (op_q inside {OP_REM, OP_REMU}) ? acc[2*LEN-1:LEN] : acc[LEN-1:0];
        if (state == S_MUL)
            fin_res = (op_q == OP_MUL) ? prod_fix[LEN-1:0] : prod_fix[2*LEN-1:LEN];
        else
            fin_res = neg_q ? -div_pick : div_pick;
    end

    // Control FSM, operand latching, iteration and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            acc         <= '0;
            opb         <= '0;
            op_q        <= '0;
            neg_q       <= 1'b0;
            out_valid_q <= 1'b0;
            aluout_q    <= '0;
            zero_q      <= 1'b1;
        end else if (bus.flush) begin
            state       <= S_IDLE;
            cnt         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        op_q  <= bus.alu_ctrl;
                        neg_q <= start_neg;
                        cnt   <= '0;
                        if (is_mul) begin
                            state       <= S_MUL;
                            acc         <= {{LEN{1'b0}}, b_mag};
                            opb         <= a_mag;
                            out_valid_q <= 1'b0;
                        end else if (go_div) begin
                            state       <= S_DIV;
                            acc         <= {{LEN{1'b0}}, a_mag};
                            opb         <= b_mag;
                            out_valid_q <= 1'b0;
                        end else begin
                            state       <= S_DONE;
                            out_valid_q <= 1'b1;
                            aluout_q    <= quick_res;
                            zero_q      <= (quick_res == '0);
                        end
                    end else if (state == S_DONE && bus.out_ready) begin
                        state       <= S_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                S_MUL, S_DIV: begin
                    if (cnt == ITERS) begin
                        state       <= S_DONE;
                        out_valid_q <= 1'b1;
                        aluout_q    <= fin_res;
                        zero_q      <= (fin_res == '0);
                    end else begin
                        acc <= (state == S_MUL) ? mul_next : div_next;
                        cnt <= cnt + (SHW+1)'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: directed scenarios followed by random
// operations compared against an arithmetic reference model.
module tb_alu_mdu;
    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    alu_mdu_if #(.LEN(32)) bus();

    alu_mdu #(.LEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference result straight from the arithmetic definition of each opcode.
    function automatic logic [31:0] model(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ub;
        logic [63:0]        p;
        logic               ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ub  = {32'b0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (c)
            5'h00: return a + b;
            5'h01: return a - b;
            5'h02: return a & b;
            5'h03: return a | b;
            5'h04: return a ^ b;
            5'h05: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'h06: return (a < b) ? 32'd1 : 32'd0;
            5'h07: return a << b[4:0];
            5'h08: return a >> b[4:0];
            5'h09: return $signed(a) >>> b[4:0];
            5'h0A: begin p = sa * sb; return p[31:0]; end
            5'h0B: begin p = sa * sb; return p[63:32]; end
            5'h0C: begin p = sa * ub; return p[63:32]; end
            5'h0D: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            5'h0E: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf)    return a;
                p = sa / sb; return p[31:0];
            end
            5'h0F: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            5'h10: begin
                if (b == 0) return a;
                if (ovf)    return 32'd0;
                p = sa % sb; return p[31:0];
            end
            5'h11: return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    // Clock edges from the accept edge to out_valid: 33 for iterative ops, 0 when
    // the result is written on the accept edge itself (one cycle after issue).
    function automatic int model_lat(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
        if (c >= 5'h0A && c <= 5'h0D) return 33;
        if (c >= 5'h0E && c <= 5'h11) begin
            if (b == 0) return 0;
            if ((c == 5'h0E || c == 5'h10) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
            return 33;
        end
        return 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, scramble the inputs after accept, wait for the result.
    task automatic run_op(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic z, output int lat, output int bad_iter);
        int guard = 0;
        bus.in_valid = 1'b1;
        bus.alu_ctrl = c;
        bus.aluop1   = a;
        bus.aluop2   = b;
        while (!bus.in_ready && guard < 200) begin
            tick();
            guard++;
        end
        check("accept_wait", 32'(guard < 200), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        bus.alu_ctrl = 5'($urandom);
        bus.aluop1   = $urandom;
        bus.aluop2   = $urandom;
        lat      = 0;
        bad_iter = 0;
        while (!bus.out_valid && lat < 200) begin
            if (bus.in_ready || !bus.busy) bad_iter++;
            tick();
            lat++;
        end
        res = bus.aluout;
        z   = bus.zero;
    endtask

    task automatic run_and_check(input string tag, input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] res, exp;
        logic        z;
        int          lat, bad;
        exp = model(c, a, b);
        run_op(c, a, b, res, z, lat, bad);
        check({tag, "_result"}, res, exp);
        check({tag, "_zero"}, 32'(z), 32'(exp == 0));
        check({tag, "_latency"}, lat, model_lat(c, a, b));
        check({tag, "_busy_iter"}, bad, 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        check({tag, "_zero"}, 32'(bus.zero), 32'd1);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_aluout"}, bus.aluout, 32'd0);
    endtask

    logic [31:0] pool [6] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1, 32'h2};

    function automatic logic [31:0] rand_operand();
        if ($urandom_range(0, 3) == 0) return pool[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    initial begin
        int rise;
        rst_n         = 1'b0;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.aluop1    = '0;
        bus.aluop2    = '0;
        bus.alu_ctrl  = '0;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        check_reset_values("reset");
        rst_n = 1'b1;
        tick();

        run_and_check("add", 5'h00, 32'd5, 32'd7);

        // Back-to-back base ops with the consumer always ready.
        run_and_check("sub", 5'h01, 32'd3, 32'd3);
        check("b2b_in_ready", 32'(bus.in_ready), 32'd1);
        run_and_check("sra", 5'h09, 32'h8000_0000, 32'd4);

        run_and_check("mul",    5'h0A, 32'hFFFF_FFFF, 32'd2);
        run_and_check("mulh",   5'h0B, 32'hFFFF_FFFF, 32'd2);
        run_and_check("mulhu",  5'h0D, 32'hFFFF_FFFF, 32'd2);
        run_and_check("mulhsu", 5'h0C, 32'hFFFF_FFFF, 32'd2);
        run_and_check("div_neg", 5'h0E, 32'hFFFF_FFF9, 32'd2);
        run_and_check("rem_neg", 5'h10, 32'hFFFF_FFF9, 32'd2);
        run_and_check("divu_zero", 5'h0F, 32'd10, 32'd0);
        run_and_check("rem_zero",  5'h10, 32'd10, 32'd0);
        run_and_check("div_ovf", 5'h0E, 32'h8000_0000, 32'hFFFF_FFFF);
        run_and_check("rem_ovf", 5'h10, 32'h8000_0000, 32'hFFFF_FFFF);
        run_and_check("unknown", 5'h15, 32'd9, 32'd9);

        // Backpressure: drain, then hold the DIVU result for five cycles.
        tick();
        bus.out_ready = 1'b0;
        run_and_check("divu_bp", 5'h0F, 32'd100, 32'd7);
        for (int i = 0; i < 5; i++) begin
            bus.aluop1 = $urandom;
            tick();
            check("bp_hold_aluout", bus.aluout, 32'd14);
            check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        tick();
        check("bp_consumed", 32'(bus.out_valid), 32'd0);

        // Flush on cycle 10 of a DIV.
        bus.in_valid = 1'b1;
        bus.alu_ctrl = 5'h0E;
        bus.aluop1   = 32'd1000;
        bus.aluop2   = 32'd3;
        tick();
        bus.in_valid = 1'b0;
        repeat (9) tick();
        check("flush_pre_busy", 32'(bus.busy), 32'd1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush_busy", 32'(bus.busy), 32'd0);
        check("flush_in_ready", 32'(bus.in_ready), 32'd1);
        rise = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid) rise++;
            tick();
        end
        check("flush_no_valid", rise, 0);

        // A request presented together with flush is discarded.
        bus.in_valid = 1'b1;
        bus.alu_ctrl = 5'h00;
        bus.aluop1   = 32'd4;
        bus.aluop2   = 32'd4;
        bus.flush    = 1'b1;
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_discard", 32'(bus.out_valid), 32'd0);
        run_and_check("add_after_flush", 5'h00, 32'd1, 32'd1);

        // Asynchronous reset in the middle of a MUL.
        bus.in_valid = 1'b1;
        bus.alu_ctrl = 5'h0A;
        bus.aluop1   = 32'd12345;
        bus.aluop2   = 32'd678;
        tick();
        bus.in_valid = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        tick();
        rst_n = 1'b1;
        tick();
        run_and_check("add_after_rst", 5'h00, 32'd1, 32'd1);

        // Random operations, including unknown codes and boundary operands.
        for (int i = 0; i < 250; i++) begin
            logic [4:0] c;
            c = 5'($urandom_range(0, 19));
            run_and_check("rand", c, rand_operand(), rand_operand());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
